prbs_burst_ctrl: RTL and testbench

Sequencing controller for the team's PRBS pattern generator. It loads a configuration when `start` is asserted and seeds an internal shared LFSR for one of four polynomials (PRBS7/15/23/31). It then emits a programmable number of fixed-length bursts separated by idle gaps, with single-bit error injection. It sits between the register/pin configuration and the serial pattern output.

---
 rtl/prbs_burst_ctrl.sv | 139 +++++++++++++
 tb/tb_prbs_burst_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_burst_ctrl.sv
// Burst sequencer around a shared PRBS7/15/23/31 LFSR: captures a configuration on start,
// emits num_bursts bursts of burst_len bits separated by gap_len idle cycles, with one-shot bit inversion.
module prbs_burst_ctrl #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8,
  parameter int NB_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       poly_sel,
  input  logic [30:0]      seed,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [GAP_W-1:0] gap_len,
  input  logic [NB_W-1:0]  num_bursts,
  input  logic             inject_err,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [NB_W-1:0]  burst_idx
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE} state_t;

  state_t           state;
  logic [1:0]       poly_r;
  logic [30:0]      seed_r;
  logic [CNT_W-1:0] burst_len_r;
  logic [GAP_W-1:0] gap_len_r;
  logic [NB_W-1:0]  num_bursts_r;
  logic [30:0]      lfsr;
  logic [30:0]      seed_masked;
  logic [CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             inj_pend;

  function automatic logic [30:0] poly_mask(input logic [1:0] p);
    case (p)
      2'd0:    return 31'h0000_007F;
      2'd1:    return 31'h0000_7FFF;
      2'd2:    return 31'h007F_FFFF;
      default: return 31'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic lfsr_msb(input logic [30:0] l, input logic [1:0] p);
    case (p)
      2'd0:    return l[6];
      2'd1:    return l[14];
      2'd2:    return l[22];
      default: return l[30];
    endcase
  endfunction

  // Shift left by one within the active width, feedback = MSB xor tap.
  function automatic logic [30:0] lfsr_next(input logic [30:0] l, input logic [1:0] p);
    case (p)
      2'd0:    return {24'd0, l[5:0],  l[6]  ^ l[5]};
      2'd1:    return {16'd0, l[13:0], l[14] ^ l[13]};
      2'd2:    return {8'd0,  l[21:0], l[22] ^ l[17]};
      default: return {l[29:0], l[30] ^ l[27]};
    endcase
  endfunction

  assign seed_masked = seed_r & poly_mask(poly_r);
  assign bit_valid   = (state == S_RUN);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign bit_out     = bit_valid & (lfsr_msb(lfsr, poly_r) ^ (inj_pend | inject_err));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      poly_r       <= '0;
      seed_r       <= '0;
      burst_len_r  <= '0;
      gap_len_r    <= '0;
      num_bursts_r <= '0;
      lfsr         <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      burst_idx    <= '0;
      inj_pend     <= 1'b0;
    end else begin
      if (inject_err) inj_pend <= 1'b1;
      if (abort) begin
        state <= S_IDLE;
        if (state != S_IDLE) inj_pend <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && burst_len != '0) begin
              poly_r       <= poly_sel;
              seed_r       <= seed;
              burst_len_r  <= burst_len;
              gap_len_r    <= gap_len;
              num_bursts_r <= num_bursts;
              state        <= S_LOAD;
            end
          end
          S_LOAD: begin
            lfsr      <= (seed_masked == '0) ? 31'd1 : seed_masked;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            burst_idx <= '0;
            state     <= S_RUN;
          end
          S_RUN: begin
            inj_pend <= 1'b0;
            lfsr     <= lfsr_next(lfsr, poly_r);
            if (bit_cnt == burst_len_r - CNT_W'(1)) begin
              bit_cnt <= '0;
              if (num_bursts_r != '0 && burst_idx == num_bursts_r - NB_W'(1)) begin
                state <= S_DONE;
              end else begin
                burst_idx <= burst_idx + NB_W'(1);
                if (gap_len_r != '0) begin
                  gap_cnt <= '0;
                  state   <= S_GAP;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          S_GAP: begin
            if (gap_cnt == gap_len_r - GAP_W'(1)) state <= S_RUN;
            else gap_cnt <= gap_cnt + GAP_W'(1);
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Bench for prbs_burst_ctrl: per-cycle comparison against a sequence-level PRBS/burst model.
module tb_prbs_burst_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, abort, inject_err;
  logic [1:0]  poly_sel;
  logic [30:0] seed;
  logic [15:0] burst_len;
  logic [7:0]  gap_len, num_bursts;
  logic        bit_out, bit_valid, busy, done;
  logic [7:0]  burst_idx;

  int n_total = 0;
  int n_pass  = 0;

  bit s [0:1023];
  bit e_valid [0:1099];
  bit e_bit   [0:1099];
  bit e_busy  [0:1099];
  bit e_done  [0:1099];
  int e_idx   [0:1099];

  prbs_burst_ctrl #(.CNT_W(16), .GAP_W(8), .NB_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .poly_sel(poly_sel),
    .seed(seed), .burst_len(burst_len), .gap_len(gap_len), .num_bursts(num_bursts),
    .inject_err(inject_err), .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy),
    .done(done), .burst_idx(burst_idx)
  );

  always #5 clk = ~clk;

  // Model: output sequence obeys s[m] = s[m-W] ^ s[m-T]; first W bits are the seed MSB-first.
  // Cycle 0 is the LOAD cycle following the accepting start edge.
  task automatic build_expect(input int p, input int sd, input int bl, input int gl,
                              input int nb, input int ncyc);
    int w, t, c, k, b;
    int unsigned m;
    bit fin;
    w = (p == 0) ? 7 : (p == 1) ? 15 : (p == 2) ? 23 : 31;
    t = (p == 0) ? 6 : (p == 1) ? 14 : (p == 2) ? 18 : 28;
    m = int'(sd) & ((32'h1 << w) - 1);
    if (m == 0) m = 1;
    for (int n = 0; n < w; n++) s[n] = bit'((m >> (w - 1 - n)) & 1);
    for (int n = w; n < 1024; n++) s[n] = s[n - w] ^ s[n - t];
    for (int i = 0; i < ncyc; i++) begin
      e_valid[i] = 0; e_bit[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_idx[i] = -1;
    end
    e_busy[0] = 1;
    c = 1; k = 0; b = 0; fin = 0;
    while (c < ncyc && !fin) begin
      for (int q = 0; q < bl && c < ncyc; q++) begin
        e_valid[c] = 1; e_bit[c] = s[k]; e_busy[c] = 1; e_idx[c] = b % 256;
        c++; k++;
      end
      if (nb != 0 && b == nb - 1) begin
        if (c < ncyc) begin e_done[c] = 1; e_busy[c] = 1; e_idx[c] = b; end
        c++;
        fin = 1;
      end else begin
        b++;
        for (int g = 0; g < gl && c < ncyc; g++) begin
          e_busy[c] = 1; e_idx[c] = b % 256;
          c++;
        end
      end
    end
    if (fin) for (; c < ncyc; c++) e_idx[c] = b;
  endtask

  // Accept a configuration, then scramble the inputs to show they were captured.
  task automatic kick(input int p, input int sd, input int bl, input int gl, input int nb);
    @(negedge clk);
    poly_sel = 2'(p); seed = 31'(sd); burst_len = 16'(bl); gap_len = 8'(gl);
    num_bursts = 8'(nb); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    poly_sel = 2'($urandom); seed = 31'($urandom); burst_len = 16'($urandom);
    gap_len = 8'($urandom); num_bursts = 8'($urandom);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; abort = 0; inject_err = 0;
    poly_sel = 0; seed = 0; burst_len = 0; gap_len = 0; num_bursts = 0;
    #12;
    n_total++;
    if ({bit_out, bit_valid, busy, done, burst_idx} !== 12'd0)
      $display("FAIL reset_outputs: got %h want 000", {bit_out, bit_valid, busy, done, burst_idx});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bit_valid, busy, done} !== 3'b000)
      $display("FAIL reset_release_idle: got %b want 000", {bit_valid, busy, done});
    else n_pass++;
  endtask

  task automatic test_prbs31;
    int nv, nd;
    nv = 0; nd = 0;
    build_expect(3, 1, 40, 0, 1, 44);
    kick(3, 1, 40, 0, 1);
    for (int c = 0; c < 44; c++) begin
      n_total++;
      if ({bit_valid, bit_out, busy, done} !== {e_valid[c], e_bit[c], e_busy[c], e_done[c]})
        $display("FAIL prbs31 cyc %0d: got vbBd=%b want %b", c, {bit_valid, bit_out, busy, done},
                 {e_valid[c], e_bit[c], e_busy[c], e_done[c]});
      else n_pass++;
      nv += int'(bit_valid); nd += int'(done);
      @(negedge clk);
    end
    n_total++;
    if (nv != 40) $display("FAIL prbs31_valid_count: got %0d want 40", nv); else n_pass++;
    n_total++;
    if (nd != 1) $display("FAIL prbs31_done_count: got %0d want 1", nd); else n_pass++;
  endtask

  task automatic test_prbs7_period;
    bit obs [0:253];
    int nv, bad, run, maxrun;
    nv = 0;
    build_expect(0, 'h7F, 254, 0, 1, 258);
    kick(0, 'h7F, 254, 0, 1);
    for (int c = 0; c < 258; c++) begin
      n_total++;
      if ({bit_valid, bit_out, busy, done} !== {e_valid[c], e_bit[c], e_busy[c], e_done[c]})
        $display("FAIL prbs7 cyc %0d: got vbBd=%b want %b", c, {bit_valid, bit_out, busy, done},
                 {e_valid[c], e_bit[c], e_busy[c], e_done[c]});
      else n_pass++;
      if (bit_valid && nv < 254) begin obs[nv] = bit_out; nv++; end
      @(negedge clk);
    end
    bad = 0; run = 0; maxrun = 0;
    for (int n = 0; n < 127; n++) if (obs[n] != obs[n + 127]) bad++;
    for (int n = 0; n < 254; n++) begin
      run = obs[n] ? 0 : run + 1;
      if (run > maxrun) maxrun = run;
    end
    n_total++;
    if (bad != 0) $display("FAIL prbs7_period: got %0d differing bits want 0", bad); else n_pass++;
    n_total++;
    if (maxrun >= 7) $display("FAIL prbs7_zero_run: got run %0d want <7", maxrun); else n_pass++;
  endtask

  task automatic test_bursts_gaps;
    int p, sd;
    logic [10:0] vpat;
    p = int'($urandom_range(0, 3)); sd = int'($urandom);
    vpat = '0;
    build_expect(p, sd, 4, 3, 2, 15);
    kick(p, sd, 4, 3, 2);
    for (int c = 0; c < 15; c++) begin
      n_total++;
      if ({bit_valid, bit_out, busy, done} !== {e_valid[c], e_bit[c], e_busy[c], e_done[c]})
        $display("FAIL bursts_gaps cyc %0d: got vbBd=%b want %b", c, {bit_valid, bit_out, busy, done},
                 {e_valid[c], e_bit[c], e_busy[c], e_done[c]});
      else n_pass++;
      if (e_idx[c] >= 0) begin
        n_total++;
        if (burst_idx !== 8'(e_idx[c]))
          $display("FAIL bursts_gaps_idx cyc %0d: got %0d want %0d", c, burst_idx, e_idx[c]);
        else n_pass++;
      end
      if (c >= 1 && c <= 11) vpat[11 - c] = bit_valid;
      @(negedge clk);
    end
    n_total++;
    if (vpat !== 11'b11110001111)
      $display("FAIL bursts_gaps_pattern: got %b want 11110001111", vpat);
    else n_pass++;
  endtask

  task automatic test_zero_seed;
    build_expect(1, 1, 30, 0, 1, 33);
    kick(1, 0, 30, 0, 1);
    for (int c = 0; c < 33; c++) begin
      n_total++;
      if ({bit_valid, bit_out, busy, done} !== {e_valid[c], e_bit[c], e_busy[c], e_done[c]})
        $display("FAIL zero_seed cyc %0d: got vbBd=%b want %b", c, {bit_valid, bit_out, busy, done},
                 {e_valid[c], e_bit[c], e_busy[c], e_done[c]});
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_start;
    @(negedge clk);
    burst_len = 16'd0; gap_len = 8'd2; num_bursts = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_total++;
      if ({busy, done, bit_valid} !== 3'b000)
        $display("FAIL illegal_start cyc %0d: got busy/done/valid=%b want 000", c, {busy, done, bit_valid});
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_abort_inject;
    int p, sd;
    p = int'($urandom_range(0, 3)); sd = int'($urandom);
    build_expect(p, sd, 4, 3, 0, 11);
    e_bit[8] = ~e_bit[8];
    kick(p, sd, 4, 3, 0);
    for (int c = 0; c < 11; c++) begin
      n_total++;
      if ({bit_valid, bit_out, busy, done} !== {e_valid[c], e_bit[c], e_busy[c], e_done[c]})
        $display("FAIL inject cyc %0d: got vbBd=%b want %b", c, {bit_valid, bit_out, busy, done},
                 {e_valid[c], e_bit[c], e_busy[c], e_done[c]});
      else n_pass++;
      if (c == 5) inject_err = 1'b1;
      if (c == 6) inject_err = 1'b0;
      if (c == 10) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_total++;
      if ({bit_valid, busy, done} !== 3'b000)
        $display("FAIL abort cyc %0d: got valid/busy/done=%b want 000", c, {bit_valid, busy, done});
      else n_pass++;
      @(negedge clk);
    end
    sd = int'($urandom);
    build_expect(p, sd, 6, 1, 1, 10);
    kick(p, sd, 6, 1, 1);
    for (int c = 0; c < 10; c++) begin
      n_total++;
      if ({bit_valid, bit_out, busy, done} !== {e_valid[c], e_bit[c], e_busy[c], e_done[c]})
        $display("FAIL restart cyc %0d: got vbBd=%b want %b", c, {bit_valid, bit_out, busy, done},
                 {e_valid[c], e_bit[c], e_busy[c], e_done[c]});
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int p, sd, bl, gl, nb, n;
    for (int it = 0; it < 8; it++) begin
      p  = int'($urandom_range(0, 3)); sd = int'($urandom);
      bl = int'($urandom_range(1, 20)); gl = int'($urandom_range(0, 4));
      nb = int'($urandom_range(1, 4));
      n  = 1 + nb * bl + (nb - 1) * gl + 3;
      build_expect(p, sd, bl, gl, nb, n);
      kick(p, sd, bl, gl, nb);
      for (int c = 0; c < n; c++) begin
        n_total++;
        if ({bit_valid, bit_out, busy, done} !== {e_valid[c], e_bit[c], e_busy[c], e_done[c]})
          $display("FAIL random it%0d cyc %0d: got vbBd=%b want %b", it, c,
                   {bit_valid, bit_out, busy, done}, {e_valid[c], e_bit[c], e_busy[c], e_done[c]});
        else n_pass++;
        if (e_idx[c] >= 0) begin
          n_total++;
          if (burst_idx !== 8'(e_idx[c]))
            $display("FAIL random_idx it%0d cyc %0d: got %0d want %0d", it, c, burst_idx, e_idx[c]);
          else n_pass++;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid;
    kick(3, int'($urandom), 50, 0, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bit_out, bit_valid, busy, done, burst_idx} !== 12'd0)
      $display("FAIL reset_mid: got %h want 000", {bit_out, bit_valid, busy, done, burst_idx});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++;
      if ({bit_valid, busy, done} !== 3'b000)
        $display("FAIL reset_mid_idle cyc %0d: got %b want 000", c, {bit_valid, busy, done});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_prbs31;
    test_prbs7_period;
    test_bursts_gaps;
    test_zero_seed;
    test_illegal_start;
    test_abort_inject;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
